tcdm_burst_reader: RTL and testbench

- Read-side initiator for the tile's word-interleaved L1: 32 banks × 8192 words, 32-bit words.
- Accepts a burst command (start byte address, word count) and issues single-word TCDM reads, one per cycle at most.
- Buffers the returned data and presents it as a valid/ready word stream.
- Used by the tile testbench and the L1 dump path to read out bank memory that was filled by the preload writer.

---
 rtl/tcdm_burst_reader_pkg.sv | 20 ++
 rtl/tcdm_burst_fifo.sv | 60 ++++++
 rtl/tcdm_burst_reader.sv | 158 +++++++++++++++
 tb/tb_tcdm_burst_reader.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_burst_reader_pkg.sv
// Shared tile package: L1 geometry, derived address/length widths and the
// burst reader state type.
package tcdm_burst_reader_pkg;

   localparam int N_MEM_BANKS  = 32;
   localparam int N_WORDS_BANK = 8192;

   localparam int BANK_W  = $clog2(N_MEM_BANKS);
   localparam int ROW_W   = $clog2(N_WORDS_BANK);
   localparam int WADDR_W = BANK_W + ROW_W;
   localparam int ADDR_W  = WADDR_W + 2;
   localparam int LEN_W   = WADDR_W + 1;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ISSUE,
      RD_DRAIN
   } rd_state_e;

endpackage

// File: rtl/tcdm_burst_fifo.sv
// Synchronous response FIFO for the burst reader: push/pop, occupancy count
// and a synchronous flush.
module tcdm_burst_fifo #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty_o;

   // NOTE: the storage array has no reset; count_q alone decides which
   // entries hold valid data, so stale contents are never observed.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/tcdm_burst_reader.sv
// Read-side TCDM initiator: turns a (byte address, word count) command into
// single-word bank reads and streams the returned words out valid/ready.
module tcdm_burst_reader
   import tcdm_burst_reader_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   output logic              tcdm_req_o,
   input  logic              tcdm_gnt_i,
   output logic [BANK_W-1:0] tcdm_bank_o,
   output logic [ROW_W-1:0]  tcdm_row_o,
   output logic              tcdm_wen_o,
   input  logic              tcdm_r_valid_i,
   input  logic [DATA_W-1:0] tcdm_r_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_last_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   rd_state_e          state_q, state_d;
   logic [WADDR_W-1:0] waddr_q;
   logic [LEN_W-1:0]   issue_cnt_q;
   logic [LEN_W-1:0]   deliver_cnt_q;
   logic               inflight_q;
   logic               ready_en_q;
   logic               done_q;
   logic               done_d;

   logic               cmd_fire;
   logic               grant;
   logic               push;
   logic               pop;
   logic               burst_end;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   occupancy;
   logic               fifo_empty;
   logic [DATA_W-1:0]  fifo_head;
   logic               unused_addr_lsbs;

   assign unused_addr_lsbs = ^cmd_addr_i[1:0];

   // Credit: words buffered plus the one read still on its way back.
   assign occupancy = fifo_count + CNT_W'(inflight_q);
   assign cmd_fire  = cmd_valid_i && cmd_ready_o;
   assign grant     = tcdm_req_o && tcdm_gnt_i;
   assign push      = tcdm_r_valid_i && inflight_q;
   assign pop       = out_valid_o && out_ready_i;
   assign burst_end = pop && out_last_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cmd_ready_o = 1'b0;
      tcdm_req_o  = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         RD_IDLE: begin
            cmd_ready_o = ready_en_q;
            if (cmd_valid_i && ready_en_q) begin
               if (cmd_len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RD_ISSUE;
               end
            end
         end
         RD_ISSUE: begin
            tcdm_req_o = (occupancy < CNT_W'(FIFO_DEPTH));
            if (tcdm_req_o && tcdm_gnt_i && issue_cnt_q == LEN_W'(1)) begin
               state_d = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (burst_end) begin
               done_d  = 1'b1;
               state_d = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         waddr_q       <= '0;
         issue_cnt_q   <= '0;
         deliver_cnt_q <= '0;
         inflight_q    <= 1'b0;
         ready_en_q    <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         done_q     <= done_d;
         inflight_q <= grant;
         if (cmd_fire) begin
            waddr_q       <= cmd_addr_i[ADDR_W-1:2];
            issue_cnt_q   <= cmd_len_i;
            deliver_cnt_q <= cmd_len_i;
         end else begin
            if (grant) begin
               waddr_q     <= waddr_q + 1'b1;
               issue_cnt_q <= issue_cnt_q - 1'b1;
            end
            if (pop) begin
               deliver_cnt_q <= deliver_cnt_q - 1'b1;
            end
         end
      end
   end

   tcdm_burst_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (cmd_fire),
      .push_i      (push),
      .push_data_i (tcdm_r_data_i),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign tcdm_bank_o = waddr_q[BANK_W-1:0];
   assign tcdm_row_o  = waddr_q[WADDR_W-1:BANK_W];
   assign tcdm_wen_o  = 1'b1;
   assign out_valid_o = !fifo_empty;
   assign out_data_o  = out_valid_o ? fifo_head : '0;
   assign out_last_o  = out_valid_o && (deliver_cnt_q == LEN_W'(1));
   assign busy_o      = (state_q != RD_IDLE);
   assign done_o      = done_q;

endmodule

// File: tb/tb_tcdm_burst_reader.sv
// Self-checking bench for tcdm_burst_reader: a transaction-level model
// (address sequence, credit limit, response delay, stream order) checked
// every cycle, plus literal expectations for the directed bursts.
module tb_tcdm_burst_reader;
   import tcdm_burst_reader_pkg::*;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [LEN_W-1:0]  cmd_len_i;
   logic              tcdm_req_o;
   logic              tcdm_gnt_i;
   logic [BANK_W-1:0] tcdm_bank_o;
   logic [ROW_W-1:0]  tcdm_row_o;
   logic              tcdm_wen_o;
   logic              tcdm_r_valid_i;
   logic [DATA_W-1:0] tcdm_r_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;
   logic              out_last_o;
   logic              busy_o;
   logic              done_o;

   tcdm_burst_reader #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .cmd_valid_i    (cmd_valid_i),
      .cmd_ready_o    (cmd_ready_o),
      .cmd_addr_i     (cmd_addr_i),
      .cmd_len_i      (cmd_len_i),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_bank_o    (tcdm_bank_o),
      .tcdm_row_o     (tcdm_row_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .tcdm_r_data_i  (tcdm_r_data_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_data_o     (out_data_o),
      .out_last_o     (out_last_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory contents: unique word per (bank,row).
   function automatic logic [31:0] data_of(input logic [4:0] bank, input logic [12:0] row);
      return {row, 6'h2A, bank, 8'hA5};
   endfunction

   function automatic logic [WADDR_W-1:0] waddr_of(input logic [ADDR_W-1:0] a, input int i);
      logic [WADDR_W-1:0] w;
      w = a[ADDR_W-1:2];
      return w + WADDR_W'(i);
   endfunction

   // Stimulus controls
   bit gnt_rand  = 1'b0;
   int ready_low = 0;
   bit inject_rv = 1'b0;

   // Model state
   int          exp_bank_q[$];
   int          exp_row_q[$];
   logic [31:0] exp_data_q[$];
   int          rem_issue, outstanding, visible, deliver_left;
   bit          busy_m, done_m, gnt_d1, gnt_d2, model_gnt;
   bit          exp_ready, exp_req;
   int          age, rst_hold, cyc;
   bit          resp_pend;
   logic [31:0] resp_data;
   int          grant_bank[$];
   int          grant_row[$];
   int          delivered, acc_cnt, done_cnt, accept_cyc, done_cyc;

   task automatic model_clear();
      exp_bank_q.delete();
      exp_row_q.delete();
      exp_data_q.delete();
      rem_issue = 0; outstanding = 0; visible = 0; deliver_left = 0;
      busy_m = 0; done_m = 0; gnt_d1 = 0; gnt_d2 = 0;
      resp_pend = 0; age = 0;
   endtask

   // Input driver: grant, stream ready and one-cycle-delayed read response.
   initial begin
      tcdm_gnt_i     = 1'b0;
      out_ready_i    = 1'b0;
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i  = '0;
      forever begin
         @(posedge clk); #1;
         tcdm_gnt_i = gnt_rand ? (($urandom & 1) == 1) : 1'b1;
         if (ready_low > 0) begin
            out_ready_i = 1'b0;
            ready_low--;
         end else begin
            out_ready_i = 1'b1;
         end
         tcdm_r_valid_i = resp_pend || inject_rv;
         tcdm_r_data_i  = resp_pend ? resp_data : 32'hDEAD_0000;
         inject_rv      = 1'b0;
      end
   end

   // Compare process: model advanced and DUT checked once per cycle.
   initial begin
      model_clear();
      rst_hold = 0; cyc = 0; delivered = 0; acc_cnt = 0; done_cnt = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_i) begin
            rst_hold++;
            if (rst_hold >= 2) begin
               check("rst_req",       tcdm_req_o,  0);
               check("rst_out_valid", out_valid_o, 0);
               check("rst_out_last",  out_last_o,  0);
               check("rst_out_data",  out_data_o,  0);
               check("rst_busy",      busy_o,      0);
               check("rst_done",      done_o,      0);
               check("rst_cmd_ready", cmd_ready_o, 0);
            end
            model_clear();
         end else begin
            rst_hold = 0;
            age++;
            exp_ready = (age >= 2) && !busy_m;
            exp_req   = (rem_issue > 0) && (outstanding < DEPTH);
            if (gnt_d2) visible++;

            check("cmd_ready", cmd_ready_o, exp_ready);
            check("busy",      busy_o,      busy_m);
            check("done",      done_o,      done_m);
            check("req",       tcdm_req_o,  exp_req);
            check("out_valid", out_valid_o, visible > 0);
            if (done_o) begin
               done_cnt++;
               done_cyc = cyc;
            end
            done_m = 0;

            resp_pend = tcdm_req_o && tcdm_gnt_i;
            resp_data = data_of(tcdm_bank_o, tcdm_row_o);

            model_gnt = 0;
            if (tcdm_req_o && exp_req && exp_bank_q.size() > 0) begin
               check("wen",  tcdm_wen_o,  1);
               check("bank", tcdm_bank_o, exp_bank_q[0]);
               check("row",  tcdm_row_o,  exp_row_q[0]);
               if (tcdm_gnt_i) begin
                  model_gnt = 1;
                  grant_bank.push_back(exp_bank_q[0]);
                  grant_row.push_back(exp_row_q[0]);
                  void'(exp_bank_q.pop_front());
                  void'(exp_row_q.pop_front());
                  rem_issue--;
                  outstanding++;
               end
            end

            if (out_valid_o && out_ready_i && visible > 0 && exp_data_q.size() > 0) begin
               check("out_data", out_data_o, exp_data_q[0]);
               check("out_last", out_last_o, deliver_left == 1);
               void'(exp_data_q.pop_front());
               visible--;
               outstanding--;
               deliver_left--;
               delivered++;
               if (deliver_left == 0) begin
                  done_m = 1;
                  busy_m = 0;
               end
            end

            gnt_d2 = gnt_d1;
            gnt_d1 = model_gnt;

            if (cmd_valid_i && exp_ready) begin
               acc_cnt++;
               accept_cyc = cyc;
               if (cmd_len_i == '0) begin
                  done_m = 1;
               end else begin
                  busy_m       = 1;
                  rem_issue    = int'(cmd_len_i);
                  deliver_left = int'(cmd_len_i);
                  for (int i = 0; i < int'(cmd_len_i); i++) begin
                     logic [WADDR_W-1:0] w;
                     w = waddr_of(cmd_addr_i, i);
                     exp_bank_q.push_back(int'(w[BANK_W-1:0]));
                     exp_row_q.push_back(int'(w[WADDR_W-1:BANK_W]));
                     exp_data_q.push_back(data_of(w[BANK_W-1:0], w[WADDR_W-1:BANK_W]));
                  end
               end
            end
         end
      end
   end

   task automatic start_burst(input logic [ADDR_W-1:0] addr, input int len);
      int base;
      bit acc;
      base = acc_cnt;
      acc  = 0;
      grant_bank.delete();
      grant_row.delete();
      delivered = 0;
      @(posedge clk); #1;
      cmd_addr_i  = addr;
      cmd_len_i   = LEN_W'(len);
      cmd_valid_i = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(posedge clk); #1;
         if (acc_cnt != base) acc = 1;
      end
      check("cmd_accepted", acc, 1);
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      int base;
      bit seen;
      base = done_cnt;
      seen = 0;
      for (int k = 0; k < 2000 && !seen; k++) begin
         @(negedge clk); #1;
         if (done_cnt != base) seen = 1;
      end
      check("done_seen", seen, 1);
   endtask

   int rx_bank[3]   = '{31, 0, 1};
   int rx_row[3]    = '{0, 1, 1};
   int wr_bank[4]   = '{30, 31, 0, 1};
   int wr_row[4]    = '{8191, 8191, 0, 0};
   int seen_valid;

   initial begin
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_len_i   = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk); #1;
      check("post_rst_ready_c1", cmd_ready_o, 0);
      check("post_rst_valid_c1", out_valid_o, 0);
      @(negedge clk); #1;
      check("post_rst_ready_c2", cmd_ready_o, 1);

      // Basic burst
      start_burst(20'h00000, 4);
      wait_done();
      check("basic_ngrants", grant_bank.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("basic_bank%0d", i), grant_bank[i], i);
         check($sformatf("basic_row%0d", i), grant_row[i], 0);
      end
      check("basic_nwords", delivered, 4);
      check("basic_done_latency", done_cyc - accept_cyc, 7);

      // Row crossing
      start_burst(20'h0007C, 3);
      wait_done();
      check("rowx_ngrants", grant_bank.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rowx_bank%0d", i), grant_bank[i], rx_bank[i]);
         check($sformatf("rowx_row%0d", i), grant_row[i], rx_row[i]);
      end

      // Wrap-around
      start_burst(20'hFFFF8, 4);
      wait_done();
      check("wrap_ngrants", grant_bank.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wrap_bank%0d", i), grant_bank[i], wr_bank[i]);
         check($sformatf("wrap_row%0d", i), grant_row[i], wr_row[i]);
      end

      // Backpressure
      ready_low = 25;
      start_burst(20'h00100, 16);
      repeat (15) @(negedge clk);
      #1;
      check("bp_grants_stalled", grant_bank.size(), DEPTH);
      check("bp_req_low", tcdm_req_o, 0);
      wait_done();
      check("bp_ngrants", grant_bank.size(), 16);
      check("bp_nwords", delivered, 16);

      // Random grant stalls
      gnt_rand = 1'b1;
      start_burst(20'h02000, 8);
      wait_done();
      gnt_rand = 1'b0;
      check("rnd_ngrants", grant_bank.size(), 8);
      check("rnd_nwords", delivered, 8);

      // Zero-length command
      start_burst(20'h00040, 0);
      wait_done();
      check("len0_ngrants", grant_bank.size(), 0);
      check("len0_done_latency", done_cyc - accept_cyc, 1);

      // Reset mid-burst with a stray response afterwards
      start_burst(20'h00300, 16);
      repeat (5) @(posedge clk);
      #1 rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      inject_rv = 1'b1;
      @(negedge clk); #1;
      check("midrst_ready_c1", cmd_ready_o, 0);
      check("midrst_valid_c1", out_valid_o, 0);
      @(negedge clk); #1;
      check("midrst_ready_c2", cmd_ready_o, 1);
      seen_valid = 0;
      repeat (5) begin
         @(negedge clk); #1;
         if (out_valid_o) seen_valid++;
      end
      check("midrst_no_valid", seen_valid, 0);

      // Recovery burst after reset
      start_burst(20'h01000, 2);
      wait_done();
      check("rec_ngrants", grant_bank.size(), 2);
      check("rec_bank0", grant_bank[0], 0);
      check("rec_row0", grant_row[0], 32);
      check("rec_bank1", grant_bank[1], 1);
      check("rec_nwords", delivered, 2);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
